// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: buffers host samples in a small FIFO and hands one
// sample per sample period to the dac_spi serializer over a dac_rq/dac_st
// handshake. Flags FIFO underrun and ticks that land on an in-flight frame.
// Optional build macro: DAC_SCHED_MIDSCALE_EN (underrun ticks output 16'h8000
// instead of repeating the previous sample).
module dac_sample_scheduler #(
  parameter int unsigned CLKS_PER_SAMPLE = 1000,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned START_LEVEL     = 8
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   in_data,
  input  logic                          in_rq,
  output logic                          in_ack,
  output logic [15:0]                   dac_data,
  output logic                          dac_rq,
  input  logic                          dac_st,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          running,
  output logic                          underrun,
  output logic                          sample_late
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_SAMPLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_REQ,
    ST_BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ack_q;
  logic [15:0]     data_q, data_d;
  logic            underrun_q, underrun_d;
  logic            late_q, late_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic            full;
  logic            empty;
  logic            wr_en;
  logic            pop;
  logic            tick;
  logic            rq;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  // The !ack_q term limits writes to one every two cycles so a held in_rq
  // is not consumed twice before the producer sees the ack.
  assign wr_en = in_rq && !full && !ack_q;
  assign tick  = (state_q != ST_IDLE) && (cnt_q == CW'(CLKS_PER_SAMPLE - 1));

  // Sample-period counter: held at zero while idle so the first tick comes
  // a full period after playback starts.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CLKS_PER_SAMPLE - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Playback FSM: next state, pop request, output sample and sticky flags.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    rq         = 1'b0;
    data_d     = data_q;
    underrun_d = underrun_q;
    late_d     = late_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && (level_q >= LW'(START_LEVEL))) begin
          underrun_d = 1'b0;
          late_d     = 1'b0;
          state_d    = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (!empty) begin
            pop    = 1'b1;
            data_d = mem_q[rd_ptr_q];
          end else begin
            underrun_d = 1'b1;
`ifdef DAC_SCHED_MIDSCALE_EN
            data_d = 16'h8000;
`else
            data_d = data_q;
`endif
          end
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        rq = 1'b1;
        if (tick) begin
          late_d = 1'b1;
        end
        if (dac_st) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (tick) begin
          late_d = 1'b1;
        end
        if (!dac_st) begin
          state_d = enable ? ST_WAIT_TICK : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; write and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clock_in) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      underrun_q <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ack_q      <= wr_en;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      late_q     <= late_d;
    end
  end

  assign in_ack      = ack_q;
  assign dac_data    = data_q;
  assign dac_rq      = rq;
  assign fifo_level  = level_q;
  assign running     = (state_q != ST_IDLE);
  assign underrun    = underrun_q;
  assign sample_late = late_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler with a behavioural dac_spi responder.
module tb_dac_sample_scheduler;

  localparam int unsigned CPS   = 200;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned START = 4;
  localparam int unsigned LW    = 5;

`ifdef DAC_SCHED_MIDSCALE_EN
  localparam logic [15:0] UR_DATA = 16'h8000;
`else
  localparam logic [15:0] UR_DATA = 16'h0004;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [15:0]   in_data;
  logic          in_rq;
  logic          in_ack;
  logic [15:0]   dac_data;
  logic          dac_rq;
  logic          dac_st;
  logic [LW-1:0] fifo_level;
  logic          running;
  logic          underrun;
  logic          sample_late;

  always #5 clk = ~clk;

  dac_sample_scheduler #(
    .CLKS_PER_SAMPLE(CPS),
    .FIFO_DEPTH(DEPTH),
    .START_LEVEL(START)
  ) dut (
    .clock_in(clk),
    .reset(reset),
    .enable(enable),
    .in_data(in_data),
    .in_rq(in_rq),
    .in_ack(in_ack),
    .dac_data(dac_data),
    .dac_rq(dac_rq),
    .dac_st(dac_st),
    .fifo_level(fifo_level),
    .running(running),
    .underrun(underrun),
    .sample_late(sample_late)
  );

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic [15:0] caps[$];
  int unsigned caps_cyc[$];
  int          viol = 0;
  int          frames_done = 0;
  int          frame_len = 30;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture dac_data at each dac_rq rise; count rq-high-while-st-high cycles.
  initial begin
    logic prev_rq;
    prev_rq = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_rq && !prev_rq) begin
        caps.push_back(dac_data);
        caps_cyc.push_back(cyc);
      end
      if (dac_rq && dac_st) viol++;
      prev_rq = dac_rq;
    end
  end

  // Serializer model: accepts a request, holds dac_st for frame_len cycles.
  initial begin
    int len;
    dac_st = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_rq && !dac_st) begin
        #1 dac_st = 1'b1;
        len = frame_len;
        repeat (len) @(negedge clk);
        #1 dac_st = 1'b0;
        frames_done++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_sample(input logic [15:0] d, output bit acked);
    acked = 1'b0;
    @(negedge clk);
    in_rq   = 1'b1;
    in_data = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ack) begin
        acked = 1'b1;
        break;
      end
    end
    in_rq = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (caps.size() >= n) break;
      @(negedge clk);
    end
    chk(tag, 32'(caps.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    in_rq  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!dac_st && !running) break;
      @(negedge clk);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    caps.delete();
    caps_cyc.delete();
    reset = 1'b0;
  endtask

  initial begin
    bit          acked;
    int          acks;
    int          fd0;
    int unsigned target;

    reset   = 1'b1;
    enable  = 1'b0;
    in_rq   = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ack", 32'(in_ack), 32'd0);
    chk("rst_rq", 32'(dac_rq), 32'd0);
    chk("rst_data", 32'(dac_data), 32'h0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_late", 32'(sample_late), 32'd0);
    reset = 1'b0;

    // Startup: six samples, playback begins once four are buffered.
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      write_sample(16'(i), acked);
      chk("su_ack", 32'(acked), 32'd1);
      if (i == 4) begin
        chk("su_running_before", 32'(running), 32'd0);
        @(negedge clk);
        chk("su_running_after", 32'(running), 32'd1);
      end
    end
    wait_caps(6, 6 * CPS + 100, "su_caps");
    for (int i = 0; i < 6; i++) chk("su_data", 32'(caps[i]), 32'(i + 1));
    chk("su_period_a", caps_cyc[1] - caps_cyc[0], 32'd200);
    chk("su_period_b", caps_cyc[5] - caps_cyc[4], 32'd200);
    chk("su_underrun", 32'(underrun), 32'd0);

    // Full FIFO: 20 offers with playback disabled, only 16 accepted.
    do_reset();
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      write_sample(16'h0100 + 16'(k), acked);
      acks += int'(acked);
    end
    chk("full_acks", 32'(acks), 32'd16);
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_ack_low", 32'(in_ack), 32'd0);
    chk("full_running", 32'(running), 32'd0);
    enable = 1'b1;
    wait_caps(16, 16 * CPS + 200, "full_caps");
    for (int k = 0; k < 16; k++) chk("full_data", 32'(caps[k]), 32'h0100 + 32'(k));
    chk("full_drained", 32'(fifo_level), 32'd0);

    // Underrun: four samples, fifth tick finds the FIFO empty.
    do_reset();
    enable = 1'b1;
    fd0 = frames_done;
    for (int i = 1; i <= 4; i++) write_sample(16'(i), acked);
    wait_caps(5, 5 * CPS + 100, "ur_caps");
    chk("ur_last_good", 32'(caps[3]), 32'h0004);
    chk("ur_data", 32'(caps[4]), 32'(UR_DATA));
    chk("ur_flag", 32'(underrun), 32'd1);
    repeat (frame_len + 5) @(negedge clk);
    chk("ur_frames", 32'(frames_done - fd0), 32'd5);
    chk("ur_st_idle", 32'(dac_st), 32'd0);
    chk("ur_rq_low", 32'(dac_rq), 32'd0);
    chk("ur_running", 32'(running), 32'd1);

    // Late tick: a 250-cycle frame swallows one tick.
    do_reset();
    frame_len = 250;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) write_sample(16'h0021 + 16'(i), acked);
    wait_caps(1, CPS + 100, "late_caps1");
    chk("late_flag_before", 32'(sample_late), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (dac_st) break;
      @(negedge clk);
    end
    frame_len = 30;
    wait_caps(2, 3 * CPS + 100, "late_caps2");
    chk("late_next_data", 32'(caps[1]), 32'h0022);
    chk("late_gap", caps_cyc[1] - caps_cyc[0], 32'd400);
    chk("late_flag", 32'(sample_late), 32'd1);
    chk("late_rq_st_overlap", 32'(viol), 32'd0);

    // Write and pop on the same tick cycle at level 5.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) write_sample(16'h0031 + 16'(i), acked);
    wait_caps(1, CPS + 100, "sim_caps1");
    chk("sim_first", 32'(caps[0]), 32'h0031);
    chk("sim_level_a", 32'(fifo_level), 32'd5);
    target = caps_cyc[0] + 199;
    for (int i = 0; i < 250; i++) begin
      if (cyc == target) break;
      @(negedge clk);
    end
    chk("sim_align", cyc, target);
    in_rq   = 1'b1;
    in_data = 16'h0037;
    @(negedge clk);
    chk("sim_ack", 32'(in_ack), 32'd1);
    chk("sim_level_b", 32'(fifo_level), 32'd5);
    in_rq = 1'b0;
    wait_caps(7, 6 * CPS + 100, "sim_caps7");
    chk("sim_second", 32'(caps[1]), 32'h0032);
    chk("sim_written", 32'(caps[6]), 32'h0037);

    // Reset while the serializer is busy, then restart only after refill.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) write_sample(16'h0051 + 16'(i), acked);
    wait_caps(1, CPS + 100, "rb_caps1");
    for (int i = 0; i < 10; i++) begin
      if (dac_st) break;
      @(negedge clk);
    end
    chk("rb_st_high", 32'(dac_st), 32'd1);
    chk("rb_rq_dropped", 32'(dac_rq), 32'd0);
    chk("rb_level_pre", 32'(fifo_level), 32'd5);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("rb_rq", 32'(dac_rq), 32'd0);
    chk("rb_level", 32'(fifo_level), 32'd0);
    chk("rb_running", 32'(running), 32'd0);
    reset = 1'b0;
    repeat (600) @(negedge clk);
    chk("rb_no_req", 32'(caps.size()), 32'd1);
    for (int i = 0; i < 4; i++) write_sample(16'h0041 + 16'(i), acked);
    repeat (300) @(negedge clk);
    chk("rb_no_req_disabled", 32'(caps.size()), 32'd1);
    chk("rb_idle", 32'(running), 32'd0);
    enable = 1'b1;
    wait_caps(2, CPS + 100, "rb_caps2");
    chk("rb_restart_data", 32'(caps[1]), 32'h0041);
    chk("rb_rq_st_overlap", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
